word_splitter: RTL

- Inverse of the team's nibble concatenator. Accepts one W_IN-bit word and emits it as W_IN/W_OUT consecutive W_OUT-bit slices.
- Default is 8-bit in, 4-bit out. The word {In1, In0} comes back out as In0 first, then In1.
- Sits between a byte-wide producer and a nibble-wide consumer (e.g. 7-seg/LED display path). Both sides use a valid/ready handshake.
- Holds one word internally, so full throughput is maintained with back-to-back words.

---
 rtl/word_splitter.sv | 109 ++++++++++
 1 files changed

// File: rtl/word_splitter.sv
// Splits each accepted W_IN-bit word into N = W_IN/W_OUT registered W_OUT-bit slices.
// Valid/ready on both sides; a word can be taken on the last-slice cycle, so back-to-back words leave no bubble.
module word_splitter #(
    parameter int unsigned W_IN      = 8,
    parameter int unsigned W_OUT     = 4,
    parameter bit          LSB_FIRST = 1'b1
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                in_valid,
    output logic                                in_ready,
    input  logic [W_IN-1:0]                     in_data,
    output logic                                out_valid,
    input  logic                                out_ready,
    output logic [W_OUT-1:0]                    out_data,
    output logic [$clog2(W_IN/W_OUT)-1:0]       out_idx,
    output logic                                out_last
);

    localparam int unsigned N  = W_IN / W_OUT;
    localparam int unsigned IW = $clog2(N);

    typedef enum logic {
        EMPTY = 1'b0,
        BUSY  = 1'b1
    } state_e;

    state_e              state_q, state_d;
    logic [W_IN-1:0]     buf_q, buf_d;
    logic [W_OUT-1:0]    data_q, data_d;
    logic [IW-1:0]       idx_q, idx_d;
    logic [IW-1:0]       idx_nxt;
    logic                last_q, last_d;
    logic                in_xfer, out_xfer;

    // Slice k of a word in emission order.
    function automatic logic [W_OUT-1:0] slice_of(input logic [W_IN-1:0] w, input logic [IW-1:0] k);
        logic [IW-1:0] pos;
        pos = LSB_FIRST ? k : (IW'(N - 1) - k);
        return W_OUT'(w >> (W_OUT * 32'(pos)));
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (in_valid) state_d = BUSY;
            BUSY:  if (out_xfer && last_q && !in_valid) state_d = EMPTY;
        endcase
    end

    // in_ready is combinational from out_ready so the next word lands on the last-slice edge.
    always_comb begin
        out_valid = (state_q == BUSY);
        in_ready  = (state_q == EMPTY) || (out_ready && last_q);
        in_xfer   = in_valid && in_ready;
        out_xfer  = out_valid && out_ready;
    end

    always_comb begin
        buf_d   = buf_q;
        data_d  = data_q;
        idx_d   = idx_q;
        last_d  = last_q;
        idx_nxt = idx_q + 1'b1;
        if (in_xfer) begin
            buf_d  = in_data;
            idx_d  = '0;
            data_d = slice_of(in_data, '0);
            last_d = 1'b0;
        end else if (out_xfer) begin
            if (last_q) begin
                idx_d  = '0;
                data_d = '0;
                last_d = 1'b0;
            end else begin
                idx_d  = idx_nxt;
                data_d = slice_of(buf_q, idx_nxt);
                last_d = (idx_nxt == IW'(N - 1));
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q  <= '0;
            data_q <= '0;
            idx_q  <= '0;
            last_q <= 1'b0;
        end else begin
            buf_q  <= buf_d;
            data_q <= data_d;
            idx_q  <= idx_d;
            last_q <= last_d;
        end
    end

    assign out_data = data_q;
    assign out_idx  = idx_q;
    assign out_last = last_q;

endmodule
